// File: rtl/udma_smi_pkg.sv
// udma_smi_pkg: shared FSM states, requester ids and SMI direction constants
package udma_smi_pkg;
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_ARM, S_WAIT, S_DONE} smi_state_e;
  typedef enum logic {REQ_SW = 1'b0, REQ_POLL = 1'b1} req_id_e;
  localparam logic SMI_RD = 1'b0;
  localparam logic SMI_WR = 1'b1;
endpackage

// File: rtl/udma_smi_poll_timer.sv
// udma_smi_poll_timer: reloading down-counter emitting a one-cycle expire pulse every period
module udma_smi_poll_timer #(
  parameter int POLL_W = 24
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              en_i,
  input  logic [POLL_W-1:0] period_i,
  output logic              expire_o
);
  logic [POLL_W-1:0] r_cnt;
  logic              r_armed;
  logic              r_expire;
  logic [POLL_W-1:0] w_load;
  assign w_load   = (period_i == '0) ? POLL_W'(1) : period_i;
  assign expire_o = r_expire;
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_cnt    <= '0;
      r_armed  <= 1'b0;
      r_expire <= 1'b0;
    end else if (!en_i) begin
      r_cnt    <= '0;
      r_armed  <= 1'b0;
      r_expire <= 1'b0;
    end else begin
      r_expire <= r_armed && (r_cnt == POLL_W'(1));
      r_armed  <= 1'b1;
      r_cnt    <= (!r_armed || r_cnt == POLL_W'(1)) ? w_load : r_cnt - 1'b1;
    end
  end
endmodule

// File: rtl/udma_smi_sched.sv
// udma_smi_sched: round-robin arbiter between software SMI requests and periodic status polls
module udma_smi_sched
  import udma_smi_pkg::*;
#(
  parameter int POLL_W     = 24,
  parameter int TMO_CYCLES = 65536
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              sw_valid_i,
  output logic              sw_ready_o,
  input  logic              sw_rw_i,
  input  logic [4:0]        sw_phy_addr_i,
  input  logic [4:0]        sw_reg_addr_i,
  input  logic [15:0]       sw_wdata_i,
  output logic              sw_rsp_valid_o,
  output logic [15:0]       sw_rdata_o,
  output logic              sw_err_o,
  input  logic              poll_en_i,
  input  logic [POLL_W-1:0] poll_period_i,
  input  logic [4:0]        poll_phy_addr_i,
  input  logic [4:0]        poll_reg_addr_i,
  input  logic [15:0]       poll_mask_i,
  output logic [15:0]       poll_status_o,
  output logic              poll_change_o,
  output logic              poll_err_o,
  output logic              smi_start_o,
  output logic              smi_rw_o,
  output logic [4:0]        smi_phy_addr_o,
  output logic [4:0]        smi_reg_addr_o,
  output logic [15:0]       smi_wdata_o,
  input  logic              smi_busy_i,
  input  logic [15:0]       smi_rdata_i
);
  localparam int TW = (TMO_CYCLES > 2) ? $clog2(TMO_CYCLES) : 1;
  smi_state_e  r_state;
  req_id_e     r_owner;
  req_id_e     r_last;
  logic [TW-1:0] r_tmo;
  logic        r_rw;
  logic [4:0]  r_phy;
  logic [4:0]  r_reg;
  logic [15:0] r_wdata;
  logic        r_poll_pend;
  logic        r_poll_valid;
  logic        r_start;
  logic        r_rsp_valid;
  logic [15:0] r_sw_rdata;
  logic        r_sw_err;
  logic [15:0] r_poll_status;
  logic        r_poll_change;
  logic        r_poll_err;
  logic        w_expire;
  logic        w_gnt_sw;
  logic        w_gnt_poll;
  logic        w_tmo_hit;
  logic        w_done;
  udma_smi_poll_timer #(.POLL_W(POLL_W)) u_timer (
    .clk_i    (clk_i),
    .rstn_i   (rstn_i),
    .en_i     (poll_en_i),
    .period_i (poll_period_i),
    .expire_o (w_expire)
  );
  assign w_gnt_sw   = sw_valid_i && (!r_poll_pend || r_last == REQ_POLL);
  assign w_gnt_poll = r_poll_pend && !w_gnt_sw;
  assign w_tmo_hit  = (r_state == S_ARM || r_state == S_WAIT) && (r_tmo == TW'(TMO_CYCLES - 1));
  assign w_done     = w_tmo_hit || (r_state == S_WAIT && !smi_busy_i);
  assign sw_ready_o     = (r_state == S_IDLE) && w_gnt_sw;
  assign sw_rsp_valid_o = r_rsp_valid;
  assign sw_rdata_o     = r_sw_rdata;
  assign sw_err_o       = r_sw_err;
  assign poll_status_o  = r_poll_status;
  assign poll_change_o  = r_poll_change;
  assign poll_err_o     = r_poll_err;
  assign smi_start_o    = r_start;
  assign smi_rw_o       = r_rw;
  assign smi_phy_addr_o = r_phy;
  assign smi_reg_addr_o = r_reg;
  assign smi_wdata_o    = r_wdata;
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state       <= S_IDLE;
      r_owner       <= REQ_SW;
      r_last        <= REQ_POLL;
      r_tmo         <= '0;
      r_rw          <= 1'b0;
      r_phy         <= '0;
      r_reg         <= '0;
      r_wdata       <= '0;
      r_poll_pend   <= 1'b0;
      r_poll_valid  <= 1'b0;
      r_start       <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_sw_rdata    <= '0;
      r_sw_err      <= 1'b0;
      r_poll_status <= '0;
      r_poll_change <= 1'b0;
      r_poll_err    <= 1'b0;
    end else begin
      r_start       <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_sw_err      <= 1'b0;
      r_poll_change <= 1'b0;
      r_poll_err    <= 1'b0;
      r_poll_pend   <= !poll_en_i ? 1'b0 : (r_state == S_IDLE && w_gnt_poll) ? 1'b0 : w_expire ? 1'b1 : r_poll_pend;
      if (!poll_en_i) r_poll_valid <= 1'b0;
      case (r_state)
        S_IDLE: if (w_gnt_sw || w_gnt_poll) begin
          r_state <= S_ISSUE;
          r_start <= 1'b1;
          r_owner <= w_gnt_sw ? REQ_SW : REQ_POLL;
          r_last  <= w_gnt_sw ? REQ_SW : REQ_POLL;
          r_rw    <= w_gnt_sw ? sw_rw_i : SMI_RD;
          r_phy   <= w_gnt_sw ? sw_phy_addr_i : poll_phy_addr_i;
          r_reg   <= w_gnt_sw ? sw_reg_addr_i : poll_reg_addr_i;
          r_wdata <= w_gnt_sw ? sw_wdata_i : 16'h0;
        end
        S_ISSUE: begin
          r_tmo   <= '0;
          r_state <= S_ARM;
        end
        S_ARM, S_WAIT: if (w_done) begin
          r_state <= S_DONE;
          if (r_owner == REQ_SW) begin
            r_rsp_valid <= 1'b1;
            r_sw_err    <= w_tmo_hit;
            r_sw_rdata  <= (w_tmo_hit || r_rw == SMI_WR) ? 16'h0 : smi_rdata_i;
          end else if (w_tmo_hit) begin
            r_poll_err <= 1'b1;
          end else begin
            r_poll_status <= smi_rdata_i;
            r_poll_change <= r_poll_valid && poll_en_i && |((smi_rdata_i ^ r_poll_status) & poll_mask_i);
            if (poll_en_i) r_poll_valid <= 1'b1;
          end
        end else begin
          r_tmo <= r_tmo + 1'b1;
          if (r_state == S_ARM && smi_busy_i) r_state <= S_WAIT;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/udma_smi_sched.md
UDMA_SMI_SCHED -- requirements
Module: udma_smi_sched

Interface
REQ-001 SHALL have parameter POLL_W, default 24: width of the poll-period counter.
REQ-002 SHALL have parameter TMO_CYCLES, default 65536: clk_i cycles allowed per SMI transaction before abort.
REQ-003 SHALL have port clk_i, input, 1: clock.
REQ-004 SHALL have port rstn_i, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port sw_valid_i / sw_ready_o, in/out, 1/1: software request handshake.
REQ-006 SHALL have ports sw_rw_i (1, 1=write), sw_phy_addr_i (5), sw_reg_addr_i (5) and sw_wdata_i (16), all inputs: software request fields.
REQ-007 SHALL have ports sw_rsp_valid_o (1), sw_rdata_o (16) and sw_err_o (1), all outputs: software response.
REQ-008 SHALL have ports poll_en_i (1), poll_period_i (POLL_W), poll_phy_addr_i (5), poll_reg_addr_i (5) and poll_mask_i (16), all inputs: autonomous status-poll configuration.
REQ-009 SHALL have ports poll_status_o (16), poll_change_o (1) and poll_err_o (1), all outputs: last polled value, change pulse, timeout pulse.
REQ-010 SHALL have ports smi_start_o, smi_rw_o, smi_phy_addr_o[4:0], smi_reg_addr_o[4:0] and smi_wdata_o[15:0], all outputs: drive to the SMI controller.
REQ-011 SHALL have ports smi_busy_i (1) and smi_rdata_i (16), both inputs: SMI controller status and read data.

Function
REQ-012 FSM states: IDLE, ISSUE, ARM, WAIT, DONE.
REQ-013 IDLE: requesters are sw_valid_i and poll_pend; if one requester is present it is granted; if both, the one not served last is granted (round-robin); on grant go to ISSUE.
REQ-014 sw_ready_o SHALL be high only in IDLE when software is granted that cycle; sw fields are latched on sw_valid_i & sw_ready_o.
REQ-015 Poll grant SHALL issue a read (rw=0) of poll_phy_addr_i/poll_reg_addr_i sampled at grant and SHALL clear poll_pend.
REQ-016 ISSUE: smi_start_o high for exactly one cycle, smi_* fields held stable from ISSUE until DONE; go to ARM.
REQ-017 ARM: wait for smi_busy_i=1, then WAIT; WAIT: wait for smi_busy_i=0, then DONE.
REQ-018 Timeout counter SHALL clear in ISSUE and count in ARM/WAIT; on reaching TMO_CYCLES-1 go to DONE flagged as error.
REQ-019 DONE (1 cycle), software owner: sw_rsp_valid_o=1; sw_rdata_o=smi_rdata_i for reads, 16'h0 for writes or on error; sw_err_o=error; next state IDLE.
REQ-020 DONE, poll owner, no error: poll_status_o<=smi_rdata_i; poll_change_o=1 iff ((smi_rdata_i ^ poll_status_o) & poll_mask_i)!=0 and a valid prior sample exists; poll_err_o=error; next state IDLE.
REQ-021 Poll timer: while poll_en_i=1, down-counter loads poll_period_i and sets poll_pend on reaching 0, then reloads; poll_period_i=0 SHALL be treated as 1.
REQ-022 Timer expiry while poll_pend is already set SHALL be dropped (no queueing).
REQ-023 poll_en_i=0 SHALL clear the timer, poll_pend and the valid-prior-sample flag; an in-flight poll completes and updates poll_status_o with poll_change_o suppressed.
REQ-024 First poll after poll_en_i rises SHALL update poll_status_o without poll_change_o.
REQ-025 sw_rsp_valid_o, poll_change_o, poll_err_o and smi_start_o SHALL be single-cycle pulses.

Reset
REQ-026 Reset SHALL force IDLE, every output 0 (including poll_status_o), poll_pend=0, timer=0, round-robin pointer to favour software.
REQ-027 Reset mid-transaction SHALL abandon it without any response pulse.

Structure
REQ-028 Package udma_smi_pkg SHALL hold the FSM state enum, the requester-id type and the SMI_RD/SMI_WR constants.
REQ-029 Poll timer SHALL be a sub-module, udma_smi_poll_timer (inputs en, period; output expire pulse).

Verification
REQ-030 SW write phy=3 reg=0 data=16'h1140, busy high 40 cycles -> single start pulse, fields stable, sw_rsp_valid_o with rdata=0, err=0.
REQ-031 SW read, model returns 16'h796D -> sw_rdata_o=16'h796D on sw_rsp_valid_o.
REQ-032 poll_en=1, period=100, mask=16'h0004, reads 16'h0000 then 16'h0004 -> poll_change_o only on second completion, poll_status_o=16'h0004.
REQ-033 sw_valid_i held while poll_pend set, back-to-back -> grants alternate poll/sw, starting per round-robin pointer.
REQ-034 Model never raises busy, TMO_CYCLES=16 -> DONE after 16 cycles, sw_err_o=1, rdata=0; FSM returns to IDLE.
REQ-035 Assert rstn_i during WAIT -> all outputs 0 next cycle, no response pulse, new request served normally after release.
